// File: rtl/motion_alarm_pkg.sv
// motion_alarm_pkg: shared state encoding and width helpers
// for the debounced motion alarm controller.
package motion_alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PENDING  = 2'd2,
    ALARM    = 2'd3
  } state_e;

  localparam int STATE_W = 2;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int width_of(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/motion_alarm_if.sv
// motion_alarm_if: sensor/control inputs and alarm/status
// outputs of the motion alarm controller.
interface motion_alarm_if #(
  parameter int N_SENSORS = 3
);
  localparam int AW =
    motion_alarm_pkg::width_of(N_SENSORS);

  logic [N_SENSORS-1:0] m;
  logic                 arm;
  logic                 disarm;
  logic                 A;
  logic [1:0]           state;
  logic [AW-1:0]        active_cnt;
  logic [N_SENSORS-1:0] trip_mask;

  modport master (
    output m, arm, disarm,
    input  A, state, active_cnt, trip_mask
  );

  modport slave (
    input  m, arm, disarm,
    output A, state, active_cnt, trip_mask
  );

endinterface

// File: rtl/motion_alarm_ctrl_debounce.sv
// sensor_debounce: saturating run-length counter; deb is high
// once raw has been high for DEBOUNCE consecutive edges.
module sensor_debounce
  import motion_alarm_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);
  localparam int CW = width_of(DEBOUNCE);
  localparam logic [CW-1:0] MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive high samples, saturate, clear on low.
  always_comb begin
    cnt_d = cnt_q;
    if (!raw)
      cnt_d = '0;
    else if (cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // Run-length register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign deb = (cnt_q == MAX);

endmodule

// File: rtl/motion_alarm_ctrl.sv
// motion_alarm_ctrl: debounced N-sensor alarm with threshold
// trip, entry-delay countdown and latched alarm output.
module motion_alarm_ctrl
  import motion_alarm_pkg::*;
#(
  parameter int N_SENSORS = 3,
  parameter int THRESH    = 2,
  parameter int DEBOUNCE  = 4,
  parameter int ENTRY_DLY = 16
) (
  input logic           clk,
  input logic           rst_n,
  motion_alarm_if.slave bus
);
  localparam int AW = width_of(N_SENSORS);
  localparam int TW = width_of(ENTRY_DLY);
  localparam logic [AW-1:0] THR = AW'(THRESH);
  localparam logic [TW-1:0] DLY = TW'(ENTRY_DLY);
  localparam logic [TW-1:0] ONE = TW'(1);

  logic [N_SENSORS-1:0] deb;
  logic [AW-1:0]        cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [N_SENSORS-1:0] mask_q, mask_d;
  logic                 a_q, a_d;
  logic                 trip;

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.m[i]),
      .deb  (deb[i])
    );
  end

  // Population count of debounced sensors.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_SENSORS; i++)
      cnt_d = cnt_d + AW'(deb[i]);
  end

  assign trip = (cnt_q >= THR);

  // Next state; disarm overrides everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    if (bus.disarm) begin
      state_d = DISARMED;
      timer_d = '0;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        DISARMED: begin
          if (bus.arm) state_d = ARMED;
        end
        ARMED: begin
          if (trip) begin
            mask_d = deb;
            if (ENTRY_DLY == 0) begin
              state_d = ALARM;
            end else begin
              state_d = PENDING;
              timer_d = DLY;
            end
          end
        end
        PENDING: begin
          if (timer_q <= ONE)
            state_d = ALARM;
          else
            timer_d = timer_q - 1'b1;
        end
        ALARM: begin
          state_d = ALARM;
        end
        default: begin
          state_d = DISARMED;
        end
      endcase
    end
    a_d = (state_d == ALARM);
  end

  // State, timer, snapshot and alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      timer_q <= '0;
      mask_q  <= '0;
      a_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.A          = a_q;
  assign bus.state      = state_q;
  assign bus.active_cnt = cnt_q;
  assign bus.trip_mask  = mask_q;

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// tb_motion_alarm_ctrl: two instances (delayed and instant)
// driven alike and checked against a behavioural model.
module tb_motion_alarm_ctrl;
  localparam int N   = 3;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] m = '0;
  logic arm = 1'b0;
  logic disarm = 1'b0;

  always #5 clk = ~clk;

  motion_alarm_if #(.N_SENSORS(N)) b0 ();
  motion_alarm_if #(.N_SENSORS(N)) b1 ();

  assign b0.m = m;
  assign b0.arm = arm;
  assign b0.disarm = disarm;
  assign b1.m = m;
  assign b1.arm = arm;
  assign b1.disarm = disarm;

  motion_alarm_ctrl #(
    .N_SENSORS(N), .THRESH(2),
    .DEBOUNCE(DEB), .ENTRY_DLY(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  motion_alarm_ctrl #(
    .N_SENSORS(N), .THRESH(3),
    .DEBOUNCE(DEB), .ENTRY_DLY(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int thr [2] = '{2, 3};
  int dly [2] = '{16, 0};
  int run [2][N];
  int st  [2];
  int pend[2];
  int cnt [2];
  logic [N-1:0] mask[2];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      st[d] = 0;
      pend[d] = 0;
      cnt[d] = 0;
      mask[d] = '0;
      for (int i = 0; i < N; i++) run[d][i] = 0;
    end
  endtask

  // One clock edge in terms of run lengths and
  // elapsed cycles in the pending phase.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] dp;
      bit tr;
      dp = '0;
      for (int i = 0; i < N; i++)
        dp[i] = (run[d][i] >= DEB);
      tr = (cnt[d] >= thr[d]);
      if (disarm) begin
        st[d] = 0;
        mask[d] = '0;
      end else begin
        case (st[d])
          0: if (arm) st[d] = 1;
          1: if (tr) begin
            mask[d] = dp;
            if (dly[d] == 0) st[d] = 3;
            else begin
              st[d] = 2;
              pend[d] = 1;
            end
          end
          2: begin
            if (pend[d] >= dly[d]) st[d] = 3;
            else pend[d]++;
          end
          default: ;
        endcase
      end
      cnt[d] = $countones(dp);
      for (int i = 0; i < N; i++)
        run[d][i] = m[i] ? run[d][i] + 1 : 0;
    end
  endtask

  task automatic check_all();
    chk("st0", 32'(b0.state), st[0]);
    chk("a0", 32'(b0.A), 32'(st[0] == 3));
    chk("cnt0", 32'(b0.active_cnt), cnt[0]);
    chk("mask0", 32'(b0.trip_mask), 32'(mask[0]));
    chk("st1", 32'(b1.state), st[1]);
    chk("a1", 32'(b1.A), 32'(st[1] == 3));
    chk("cnt1", 32'(b1.active_cnt), cnt[1]);
    chk("mask1", 32'(b1.trip_mask), 32'(mask[1]));
  endtask

  task automatic step(input logic [N-1:0] mm,
                      input logic a,
                      input logic d);
    m = mm;
    arm = a;
    disarm = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [N-1:0] mr;
    model_reset();

    // Reset held with arbitrary inputs.
    for (int k = 0; k < 4; k++) begin
      m = N'($urandom_range(0, 7));
      arm = 1'b1;
      @(posedge clk);
      #1;
      check_all();
      chk("rst_a", 32'(b0.A), 0);
      chk("rst_st", 32'(b0.state), 0);
    end
    m = '0;
    arm = 1'b0;
    rst_n = 1'b1;

    // Single sensor never trips.
    step(3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++)
      step(3'b001, 1'b0, 1'b0);
    chk("single_cnt", 32'(b0.active_cnt), 1);
    chk("single_st", 32'(b0.state), 1);
    chk("single_a", 32'(b0.A), 0);

    // Two sensors: pending then alarm.
    for (int k = 0; k < 5; k++)
      step(3'b011, 1'b0, 1'b0);
    chk("trip_cnt", 32'(b0.active_cnt), 2);
    chk("trip_armed", 32'(b0.state), 1);
    step(3'b011, 1'b0, 1'b0);
    chk("trip_pend", 32'(b0.state), 2);
    for (int k = 0; k < 15; k++) begin
      step(3'b011, 1'b0, 1'b0);
      chk("pend_a", 32'(b0.A), 0);
    end
    step(3'b011, 1'b0, 1'b0);
    chk("alarm_a", 32'(b0.A), 1);
    chk("alarm_mask", 32'(b0.trip_mask), 3'b011);
    for (int k = 0; k < 5; k++)
      step(3'b000, 1'b0, 1'b0);
    chk("latch_a", 32'(b0.A), 1);

    // Asynchronous reset while in alarm.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a", 32'(b0.A), 0);
    chk("async_st", 32'(b0.state), 0);
    chk("async_mask", 32'(b0.trip_mask), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Glitches shorter than the debounce window.
    step(3'b000, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) begin
        step(3'b011, 1'b0, 1'b0);
        chk("glitch_cnt", 32'(b0.active_cnt), 0);
      end
      step(3'b000, 1'b0, 1'b0);
      chk("glitch_st", 32'(b0.state), 1);
    end

    // Disarm during pending, then arm+disarm.
    for (int k = 0; k < 6; k++)
      step(3'b011, 1'b0, 1'b0);
    chk("dis_pend", 32'(b0.state), 2);
    for (int k = 0; k < 10; k++)
      step(3'b011, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b1);
    chk("dis_st", 32'(b0.state), 0);
    chk("dis_mask", 32'(b0.trip_mask), 0);
    for (int k = 0; k < 20; k++) begin
      step(3'b011, 1'b0, 1'b0);
      chk("dis_a", 32'(b0.A), 0);
    end
    step(3'b011, 1'b1, 1'b1);
    chk("both_st", 32'(b0.state), 0);

    // Instant-mode instance, three sensors.
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      step(3'b111, 1'b0, 1'b0);
    chk("inst_cnt", 32'(b1.active_cnt), 3);
    chk("inst_armed", 32'(b1.state), 1);
    step(3'b111, 1'b0, 1'b0);
    chk("inst_st", 32'(b1.state), 3);
    chk("inst_a", 32'(b1.A), 1);
    chk("inst_mask", 32'(b1.trip_mask), 3'b111);
    step(3'b111, 1'b0, 1'b1);
    chk("inst_clr_a", 32'(b1.A), 0);
    chk("inst_clr_st", 32'(b1.state), 0);

    // Randomised traffic against the model.
    mr = '0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0)
        mr = N'($urandom_range(0, 7));
      step(mr,
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
